// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter merging NB_MASTERS request ports onto one L2 bank port.
// Requests pass through combinationally; the winner is remembered so the response returns to it.
module l2_bank_rr_arbiter #(
   parameter int NB_MASTERS = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NB_MASTERS-1:0]               m_req_i,
   input  logic [NB_MASTERS*ADDR_WIDTH-1:0]    m_add_i,
   input  logic [NB_MASTERS-1:0]               m_wen_i,
   input  logic [NB_MASTERS*DATA_WIDTH-1:0]    m_wdata_i,
   input  logic [NB_MASTERS*DATA_WIDTH/8-1:0]  m_be_i,
   output logic [NB_MASTERS-1:0]               m_gnt_o,
   output logic [NB_MASTERS-1:0]               m_r_valid_o,
   output logic [DATA_WIDTH-1:0]               m_r_rdata_o,
   output logic                                m_r_opc_o,
   output logic                                s_req_o,
   output logic [ADDR_WIDTH-1:0]               s_add_o,
   output logic                                s_wen_o,
   output logic [DATA_WIDTH-1:0]               s_wdata_o,
   output logic [DATA_WIDTH/8-1:0]             s_be_o,
   input  logic                                s_gnt_i,
   input  logic                                s_r_valid_i,
   input  logic [DATA_WIDTH-1:0]               s_r_rdata_i,
   input  logic                                s_r_opc_i
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int ID_WIDTH = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

   logic [ID_WIDTH-1:0] r_rr;
   logic [ID_WIDTH-1:0] r_id;
   logic                r_pend;

   logic [ID_WIDTH-1:0] w_win;
   logic [ID_WIDTH-1:0] w_rr_nxt;
   logic                w_hs;
   int                  w_off;
   int                  w_best;

   // Winner = requester with the smallest distance from the pointer, wrapping at NB_MASTERS.
   always_comb begin
      w_win  = '0;
      w_best = NB_MASTERS;
      w_off  = 0;
      for (int i = 0; i < NB_MASTERS; i++) begin
         w_off = i - int'(r_rr);
         if (w_off < 0) begin
            w_off = w_off + NB_MASTERS;
         end
         if (m_req_i[i] && (w_off < w_best)) begin
            w_best = w_off;
            w_win  = ID_WIDTH'(i);
         end
      end
   end

   assign s_req_o  = |m_req_i;
   assign w_hs     = s_req_o & s_gnt_i;
   assign w_rr_nxt = (w_win == ID_WIDTH'(NB_MASTERS - 1)) ? '0 : w_win + ID_WIDTH'(1);

   always_comb begin
      s_add_o   = '0;
      s_wen_o   = 1'b0;
      s_wdata_o = '0;
      s_be_o    = '0;
      m_gnt_o   = '0;
      for (int i = 0; i < NB_MASTERS; i++) begin
         if (w_win == ID_WIDTH'(i)) begin
            s_add_o    = m_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            s_wen_o    = m_wen_i[i];
            s_wdata_o  = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            s_be_o     = m_be_i[i*BE_WIDTH +: BE_WIDTH];
            m_gnt_o[i] = s_gnt_i & m_req_i[i];
         end
      end
   end

   // Reset also masks the response combinationally so a response in flight is never delivered.
   always_comb begin
      m_r_valid_o = '0;
      for (int i = 0; i < NB_MASTERS; i++) begin
         m_r_valid_o[i] = rst_ni & r_pend & s_r_valid_i & (r_id == ID_WIDTH'(i));
      end
   end

   assign m_r_rdata_o = s_r_rdata_i;
   assign m_r_opc_o   = s_r_opc_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rr   <= '0;
         r_id   <= '0;
         r_pend <= 1'b0;
      end else if (w_hs) begin
         r_rr   <= w_rr_nxt;
         r_id   <= w_win;
         r_pend <= 1'b1;
      end else begin
         r_pend <= 1'b0;
      end
   end

endmodule
